// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: push-side handshake between a character producer and the buffered UART transmitter
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              flush;
    modport master (output wr_data, output wr_valid, output flush, input wr_ready);
    modport slave  (input wr_data, input wr_valid, input flush, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART framer with configurable width, baud, parity and stop bits
module uart_tx_fifo #(
    parameter int DATA_W      = 8,
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               bus,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW     = $clog2(DIV);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BW     = $clog2(DATA_W);
    localparam bit PAR_EN = PARITY_MODE == 1 || PARITY_MODE == 2;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [AW:0]       r_cnt;
    state_t            r_state;
    logic [CW-1:0]     r_baud;
    logic [BW-1:0]     r_bit;
    logic              r_stop;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_txd;
    logic [DATA_W-1:0] w_head;
    logic              w_tick, w_last_stop, w_push, w_pop;
    assign w_head       = r_mem[r_rp];
    assign w_tick       = r_baud == CW'(DIV - 1);
    assign w_last_stop  = r_state == STOP && w_tick && r_stop == 1'(STOP_BITS - 1);
    assign w_push       = bus.wr_valid && bus.wr_ready && !bus.flush;
    assign w_pop        = !bus.flush && r_cnt != '0 && (r_state == IDLE || w_last_stop);
    assign bus.wr_ready = r_cnt != (AW + 1)'(FIFO_DEPTH);
    assign txd          = r_txd;
    assign busy         = r_state != IDLE;
    assign fifo_count   = r_cnt;
    // Character storage, written on accepted pushes; left unreset so it maps onto RAM
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= bus.wr_data;
    // Pointers and occupancy; flush drops everything queued, including a same-cycle push
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (bus.flush) begin
            r_rp  <= r_wp;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    // Framing FSM: a pop always starts a start bit, so stop-to-start is gapless
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
            if (w_pop) begin
                r_shift <= w_head;
                r_par   <= (^w_head) ^ (PARITY_MODE == 2);
                r_txd   <= 1'b0;
                r_state <= START;
            end else begin
                case (r_state)
                    START: if (w_tick) begin
                        r_txd   <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                    DATA: if (w_tick) begin
                        if (r_bit == BW'(DATA_W - 1)) begin
                            r_txd   <= PAR_EN ? r_par : 1'b1;
                            r_stop  <= 1'b0;
                            r_state <= PAR_EN ? PARITY : STOP;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_txd   <= r_shift[1];
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                    PARITY: if (w_tick) begin
                        r_txd   <= 1'b1;
                        r_state <= STOP;
                    end
                    STOP: if (w_tick) begin
                        if (w_last_stop) r_state <= IDLE;
                        else r_stop <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboarded frame monitor plus vector tables for the buffered UART transmitter
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uart_tx_fifo_if #(.DATA_W(8)) b0 ();
    uart_tx_fifo_if #(.DATA_W(8)) b1 ();
    uart_tx_fifo_if #(.DATA_W(8)) b2 ();
    logic       txd0, txd1, txd2, busy0, busy1, busy2;
    logic [2:0] cnt0;
    logic [4:0] cnt1, cnt2;
    uart_tx_fifo #(.DATA_W(8), .CLK_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(4), .PARITY_MODE(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst), .bus(b0), .txd(txd0), .busy(busy0), .fifo_count(cnt0));
    uart_tx_fifo #(.DATA_W(8), .CLK_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(16), .PARITY_MODE(1), .STOP_BITS(2))
        u1 (.clk(clk), .rst(rst), .bus(b1), .txd(txd1), .busy(busy1), .fifo_count(cnt1));
    uart_tx_fifo #(.DATA_W(8), .CLK_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(16), .PARITY_MODE(2), .STOP_BITS(1))
        u2 (.clk(clk), .rst(rst), .bus(b2), .txd(txd2), .busy(busy2), .fifo_count(cnt2));
    int n_checks = 0;
    int n_err = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    logic [7:0] q[$];
    int         starts[$];
    int         cyc = 0;
    int         frames = 0;
    int         m_k = 0;
    bit         m_act = 0;
    bit         m_bad = 0;
    logic [7:0] m_exp;
    logic [9:0] m_frame;
    always @(negedge clk) begin
        cyc++;
        if (rst) m_act = 0;
        else if (!m_act && txd0 === 1'b0) begin
            m_act = 1;
            m_k = 0;
            m_bad = 0;
            starts.push_back(cyc);
            chk("frame_expected", q.size() != 0, 1);
            m_exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
            m_frame = {1'b1, m_exp, 1'b0};
        end
        if (m_act) begin
            if (txd0 !== m_frame[m_k/10] || busy0 !== 1'b1) m_bad = 1;
            m_k++;
            if (m_k == 100) begin
                m_act = 0;
                frames++;
                chk($sformatf("frame_%02h_clean", m_exp), m_bad, 0);
            end
        end
    end
    task automatic push0(input logic [7:0] d);
        b0.wr_data = d;
        b0.wr_valid = 1'b1;
        q.push_back(d);
        @(posedge clk);
        #1 b0.wr_valid = 1'b0;
    endtask
    typedef struct {logic [7:0] d; logic rdy; logic [2:0] cnt;} vec_t;
    typedef struct {logic [7:0] d; logic p_even; logic p_odd;} pv_t;
    vec_t         tbl[8];
    pv_t          ptbl[3];
    int           f0, nb, pk, l1, l2;
    logic [139:0] s1, s2;
    logic [7:0]   g1, g2;
    initial begin
        tbl = '{'{8'h10, 1, 1}, '{8'h11, 1, 1}, '{8'h12, 1, 2}, '{8'h13, 1, 3},
                '{8'h14, 1, 4}, '{8'h15, 0, 4}, '{8'h16, 0, 4}, '{8'h17, 0, 4}};
        ptbl = '{'{8'h07, 1, 0}, '{8'h03, 0, 1}, '{8'hA5, 0, 1}};
        {b0.wr_data, b0.wr_valid, b0.flush} = '0;
        {b1.wr_data, b1.wr_valid, b1.flush} = '0;
        {b2.wr_data, b2.wr_valid, b2.flush} = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", txd0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_ready", b0.wr_ready, 1);
        push0(8'h55);
        @(negedge clk);
        chk("single_cnt_e0", cnt0, 1);
        chk("single_txd_e0", txd0, 1);
        @(negedge clk);
        chk("single_cnt_e1", cnt0, 0);
        chk("single_txd_e1", txd0, 0);
        nb = 1;
        repeat (119) begin
            @(negedge clk);
            nb += int'(busy0);
        end
        chk("single_busy_len", nb, 100);
        chk("single_frames", frames, 1);
        starts.delete();
        f0 = frames;
        push0(8'h41);
        push0(8'h42);
        push0(8'h43);
        pk = 0;
        repeat (320) begin
            @(negedge clk);
            if (int'(cnt0) > pk) pk = int'(cnt0);
        end
        chk("b2b_peak", pk, 2);
        chk("b2b_frames", frames - f0, 3);
        chk("b2b_starts", starts.size(), 3);
        if (starts.size() >= 3) begin
            chk("b2b_gap1", starts[1] - starts[0], 100);
            chk("b2b_gap2", starts[2] - starts[1], 100);
        end
        f0 = frames;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b0.wr_data = tbl[i].d;
            b0.wr_valid = 1'b1;
            if (tbl[i].rdy) q.push_back(tbl[i].d);
            chk($sformatf("full_ready_%0d", i), b0.wr_ready, tbl[i].rdy);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("full_cnt_%0d", i), cnt0, tbl[i].cnt);
        end
        b0.wr_valid = 1'b0;
        repeat (520) @(negedge clk);
        chk("full_frames", frames - f0, 5);
        chk("full_queue_empty", q.size(), 0);
        f0 = frames;
        push0(8'h55);
        push0(8'h01);
        push0(8'h02);
        push0(8'h03);
        @(negedge clk);
        chk("flush_pre_cnt", cnt0, 3);
        b0.flush = 1'b1;
        b0.wr_valid = 1'b1;
        b0.wr_data = 8'h99;
        q.delete();
        @(posedge clk);
        #1 {b0.flush, b0.wr_valid} = 2'b00;
        @(negedge clk);
        chk("flush_cnt", cnt0, 0);
        chk("flush_busy", busy0, 1);
        repeat (150) @(negedge clk);
        chk("flush_idle", busy0, 0);
        chk("flush_frames", frames - f0, 1);
        chk("flush_cnt_end", cnt0, 0);
        for (int r = 0; r < 3; r++) begin
            {b1.wr_data, b2.wr_data} = {ptbl[r].d, ptbl[r].d};
            {b1.wr_valid, b2.wr_valid} = 2'b11;
            @(posedge clk);
            #1 {b1.wr_valid, b2.wr_valid} = 2'b00;
            l1 = 0;
            l2 = 0;
            for (int k = 0; k < 140; k++) begin
                @(negedge clk);
                s1[k] = txd1;
                s2[k] = txd2;
                l1 += int'(busy1);
                l2 += int'(busy2);
            end
            for (int i = 0; i < 8; i++) begin
                g1[i] = s1[16+10*i];
                g2[i] = s2[16+10*i];
            end
            chk($sformatf("par_start_%0d", r), {s1[6], s2[6]}, 0);
            chk($sformatf("par_even_data_%0d", r), g1, ptbl[r].d);
            chk($sformatf("par_odd_data_%0d", r), g2, ptbl[r].d);
            chk($sformatf("par_even_bit_%0d", r), s1[96], ptbl[r].p_even);
            chk($sformatf("par_odd_bit_%0d", r), s2[96], ptbl[r].p_odd);
            chk($sformatf("par_stop_%0d", r), {s1[106], s1[116], s2[106]}, 3'b111);
            chk($sformatf("par_even_len_%0d", r), l1, 120);
            chk($sformatf("par_odd_len_%0d", r), l2, 110);
        end
        push0(8'h33);
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        q.delete();
        #1;
        chk("arst_txd", txd0, 1);
        chk("arst_busy", busy0, 0);
        chk("arst_cnt", cnt0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        f0 = frames;
        @(negedge clk);
        push0(8'hA5);
        @(negedge clk);
        chk("post_rst_cnt_e0", cnt0, 1);
        chk("post_rst_txd_e0", txd0, 1);
        @(negedge clk);
        chk("post_rst_txd_e1", txd0, 0);
        chk("post_rst_busy_e1", busy0, 1);
        repeat (110) @(negedge clk);
        chk("post_rst_frames", frames - f0, 1);
        chk("post_rst_idle", busy0, 0);
        chk("post_rst_queue", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised buffered serial transmitter. It replaces the single-byte, trigger-driven transmit path with a FIFO-fed, baud-accurate UART framer. Width, baud, parity and stop bits are all configurable. It sits between the CPU/debug logic, which pushes characters with a valid/ready handshake, and the board TX pin. The block adds buffering, back-to-back framing, parity, flush and occupancy reporting.

Parameters:
DATA_W, 8, data bits per frame (5..9), sent LSB first
CLK_HZ, 50000000, clk frequency in Hz
BAUD, 115200, line rate; bit period DIV = (CLK_HZ + BAUD/2) / BAUD cycles, DIV >= 2
FIFO_DEPTH, 16, buffer entries, power of 2, >= 2
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_data  in  DATA_W  character to send
wr_valid  in  1  wr_data is valid this cycle
wr_ready  out  1  FIFO can accept; a push occurs on a clk edge with wr_valid & wr_ready
flush  in  1  synchronous: discard all queued (not in-flight) entries
txd  out  1  serial line, idle high, registered
busy  out  1  frame in progress (state != IDLE)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued, excluding the in-flight one

Behaviour:
- Reset (async, rst=1): txd=1, busy=0, fifo_count=0, wr_ready=1, state=IDLE, baud counter=0, pointers=0. Reset mid-frame aborts the frame; txd goes high immediately and the queued data is lost.
- FIFO:
  - wr_ready = (fifo_count != FIFO_DEPTH); it is combinational from count only and does not depend on a same-cycle pop.
  - Push and pop on the same edge: count is unchanged and both operations occur.
  - Pointers wrap modulo FIFO_DEPTH.
  - Storage is an inferred RAM; the read is registered into the shift register.
- flush:
  - Sets count and the read pointer equal to the write pointer, takes effect on that edge, and any same-cycle push is dropped.
  - The in-flight frame completes normally.
  - flush has priority over a push.
- Baud counter:
  - Counts 0..DIV-1 and is cleared at every frame start.
  - The bit boundary is count==DIV-1; every bit lasts exactly DIV cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on an edge with fifo_count != 0 (and no flush), pop the head into the shift register, set txd<=0 and go to START. A word pushed into an empty FIFO at edge E0 starts its start bit at edge E1, one cycle of latency.
  - START: after DIV cycles, txd<=data[0], bit index=0, go to DATA.
  - DATA: shift at each bit boundary. After bit DATA_W-1 completes, go to PARITY if PARITY_MODE != 0, else go to STOP.
  - PARITY: txd = XOR of data bits (even), or its inverse (odd), held for DIV cycles, then STOP.
  - STOP: txd=1 for STOP_BITS*DIV cycles. At the end, if fifo_count != 0 the next word is popped on the same edge and txd<=0, so there is no idle gap between frames. Otherwise the FSM goes to IDLE.
- Frame length = (1 + DATA_W + (PARITY_MODE != 0) + STOP_BITS) * DIV cycles.
- busy=1 from the edge that enters START until the edge that returns to IDLE.
- Parity is computed from the captured word, not from the live FIFO output.
- Invalid PARITY_MODE (3) behaves as none.

Test Plan:
- Setup for all scenarios: CLK_HZ=1000000, BAUD=100000 (DIV=10), DATA_W=8, 8N1.
- Single byte: push 0x55 at edge E0 with the block idle -> txd low from E1 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10 cycles. busy high for exactly 100 cycles; fifo_count back to 0 at E1.
- Back-to-back: push 0x41, 0x42, 0x43 on consecutive cycles -> three contiguous 100-cycle frames with no idle cycle between the stop bit and the next start bit. fifo_count peaks at 2.
- Full: FIFO_DEPTH=4, hold wr_valid for 8 cycles with data 0x10..0x17 -> 0x10..0x14 accepted (one in flight plus 4 queued). wr_ready low from cycle 6; 0x15..0x17 not transmitted.
- Parity: PARITY_MODE=1, send 0x07 -> parity bit 1 and a 110-cycle frame. PARITY_MODE=2, send 0x07 -> parity bit 0. STOP_BITS=2 -> stop high for 20 cycles.
- Flush mid-frame: 3 queued behind an active 0x55 frame, assert flush for 1 cycle -> fifo_count=0 next cycle, the 0x55 frame completes intact, then IDLE.
- Reset mid-frame: assert rst during a data bit -> txd=1, busy=0, fifo_count=0 immediately (asynchronous). After release, push 0xA5 -> a clean frame starting one cycle later.
